// File: rtl/mem_sender.sv
// rtl/mem_sender.sv - streams one CICLI-byte memory block to a consumer over a dav_/rfd handshake
module mem_sender #(
  parameter int CICLI = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  enne,
  output logic [13:0] a13_a0,
  input  logic [7:0]  d7_d0,
  output logic [7:0]  dato,
  output logic        dav_,
  input  logic        rfd,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, RD, LATCH, WAITR, SEND, REL} star_t;

  localparam logic [10:0] COUNT_INIT = 11'(CICLI);

  star_t       star;
  logic [10:0] count;
  logic [13:0] base_addr;

  // Block base wraps modulo 2^14 like every other address computation.
  always_comb base_addr = 14'(int'(enne) * CICLI);

  always_ff @(posedge clock) begin
    if (reset) begin
      star   <= IDLE;
      dav_   <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      count  <= COUNT_INIT;
      a13_a0 <= '0;
      dato   <= 8'h00;
    end else begin
      done <= 1'b0;
      case (star)
        IDLE: begin
          if (start) begin
            a13_a0 <= base_addr;
            count  <= COUNT_INIT;
            busy   <= 1'b1;
            star   <= RD;
          end
        end
        RD:    star <= LATCH;
        LATCH: begin
          dato <= d7_d0;
          star <= WAITR;
        end
        WAITR: begin
          if (rfd) begin
            dav_ <= 1'b0;
            star <= SEND;
          end
        end
        SEND: begin
          if (!rfd) begin
            dav_ <= 1'b1;
            star <= REL;
          end
        end
        REL: begin
          // The consumer must be ready again before the next byte is fetched.
          if (rfd) begin
            if (count == 11'd1) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              count <= COUNT_INIT;
              star  <= IDLE;
            end else begin
              a13_a0 <= a13_a0 + 14'd1;
              count  <= count - 11'd1;
              star   <= RD;
            end
          end
        end
        default: star <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sender.sv
// tb/tb_mem_sender.sv - scoreboard bench for mem_sender with a handshaking consumer model
`timescale 1ns/1ps
module tb_mem_sender;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  enne  = 4'd0;
  logic        rfd   = 1'b1;
  logic        sel4  = 1'b0;

  logic [13:0] a_big, a_4;
  logic [7:0]  d_big = 8'h00, d_4 = 8'h00;
  logic [7:0]  dato_big, dato_4;
  logic        dav_big, dav_4, busy_big, busy_4, done_big, done_4;

  logic [13:0] addr_s;
  logic [7:0]  dato_s;
  logic        dav_s, busy_s, done_s;

  always #5 clock = ~clock;

  mem_sender #(.CICLI(1024)) dut (
    .clock(clock), .reset(reset), .start(start & ~sel4), .enne(enne),
    .a13_a0(a_big), .d7_d0(d_big), .dato(dato_big), .dav_(dav_big),
    .rfd(rfd), .busy(busy_big), .done(done_big)
  );

  mem_sender #(.CICLI(4)) dut4 (
    .clock(clock), .reset(reset), .start(start & sel4), .enne(enne),
    .a13_a0(a_4), .d7_d0(d_4), .dato(dato_4), .dav_(dav_4),
    .rfd(rfd), .busy(busy_4), .done(done_4)
  );

  // Registered memory: data for an address appears one clock later.
  always @(posedge clock) begin
    d_big <= a_big[7:0];
    d_4   <= a_4[7:0];
  end

  assign addr_s = sel4 ? a_4    : a_big;
  assign dato_s = sel4 ? dato_4 : dato_big;
  assign dav_s  = sel4 ? dav_4  : dav_big;
  assign busy_s = sel4 ? busy_4 : busy_big;
  assign done_s = sel4 ? done_4 : done_big;

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [21:0] q[$];
  int cyc = 0, byte_cnt = 0, done_cnt = 0;
  int gap_min = 0, gap_max = 0, last_fall = -1, last_rel = 0, done_cyc = 0;
  int ack_delay = 0, hold = 0, ack_left = 0, hold_left = 0, c_state = 0;
  logic prev_done = 1'b0;
  logic [7:0] held = 8'h00;

  // Consumer: takes a byte on dav_ low, holds rfd high ack_delay cycles, drops it,
  // and after the release optionally stalls the next byte in WAITR for hold cycles.
  always @(posedge clock) begin
    logic [21:0] e;
    #1;
    cyc++;
    if (reset) begin
      c_state   = 0;
      rfd       = 1'b1;
      prev_done = 1'b0;
    end else begin
      if (done_s) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_width", prev_done, 1'b0);
        check("busy_at_done", busy_s, 1'b0);
      end
      prev_done = done_s;
      case (c_state)
        0: if (!dav_s) begin
          if (q.size() == 0) check("q_underflow", q.size(), 1);
          else begin
            e = q.pop_front();
            check("byte_addr", addr_s, e[21:8]);
            check("byte_data", dato_s, e[7:0]);
          end
          byte_cnt++;
          if (last_fall >= 0) begin
            if (cyc - last_fall < gap_min) gap_min = cyc - last_fall;
            if (cyc - last_fall > gap_max) gap_max = cyc - last_fall;
          end
          last_fall = cyc;
          held = dato_s;
          if (ack_delay == 0) begin
            rfd = 1'b0;
            c_state = 2;
          end else begin
            ack_left = ack_delay;
            c_state = 1;
          end
        end
        1: begin
          check("dato_stable", dato_s, held);
          check("dav_held", dav_s, 1'b0);
          ack_left--;
          if (ack_left == 0) begin
            rfd = 1'b0;
            c_state = 2;
          end
        end
        2: if (dav_s) begin
          last_rel = cyc;
          rfd = 1'b1;
          c_state = (hold == 0) ? 0 : 3;
        end else check("dato_stable", dato_s, held);
        3: begin
          rfd = 1'b0;
          hold_left = hold;
          c_state = 4;
        end
        4: begin
          check("dav_idle_waitr", dav_s, 1'b1);
          hold_left--;
          if (hold_left == 0) begin
            rfd = 1'b1;
            c_state = 0;
          end
        end
        default: c_state = 0;
      endcase
    end
  end

  task automatic step;
    @(posedge clock);
    #2;
  endtask

  task automatic push_block(input int e, input int n);
    logic [13:0] a;
    for (int i = 0; i < n; i++) begin
      a = 14'(e * n + i);
      q.push_back({a, a[7:0]});
    end
  endtask

  // mode 1: scramble enne every cycle; mode 2: start pulse every 3 clocks
  task automatic run_block(input int e, input int n, input int ack, input int hld, input int mode);
    int bytes0, dones0;
    ack_delay = ack;
    hold      = hld;
    bytes0    = byte_cnt;
    dones0    = done_cnt;
    last_fall = -1;
    gap_min   = 1 << 30;
    gap_max   = 0;
    push_block(e, n);
    enne  = 4'(e);
    start = 1'b1;
    step;
    start = 1'b0;
    for (int k = 0; k < n * 40 + 200; k++) begin
      if (mode == 1) enne = 4'($urandom);
      if (mode == 2) start = (k % 3 == 2);
      step;
      if (done_cnt != dones0) break;
    end
    start = 1'b0;
    check("done_count", done_cnt - dones0, 1);
    check("byte_count", byte_cnt - bytes0, n);
    check("q_empty", q.size(), 0);
    check("busy_after", busy_s, 1'b0);
  endtask

  initial begin
    int bytes0, saved;

    // Reset with start held high: reset must win.
    sel4  = 1'b0;
    reset = 1'b1;
    start = 1'b1;
    enne  = 4'd7;
    step;
    step;
    check("rst_dav", dav_big, 1'b1);
    check("rst_busy", busy_big, 1'b0);
    check("rst_done", done_big, 1'b0);
    check("rst_addr", a_big, 14'h0000);
    check("rst_dato", dato_big, 8'h00);
    check("rst_busy4", busy_4, 1'b0);
    reset = 1'b0;
    start = 1'b0;
    step;
    check("idle_busy", busy_big, 1'b0);

    // Block 2, consumer answers immediately: 5 clocks per byte.
    run_block(2, 1024, 0, 0, 0);
    check("gap_min", gap_min, 5);
    check("gap_max", gap_max, 5);

    // Stalled consumer, enne churning during the transfer.
    run_block(5, 1024, 3, 20, 1);

    // Top block with start pulses during the transfer.
    run_block(15, 1024, 0, 0, 2);
    repeat (6) step;
    check("no_restart", busy_big, 1'b0);

    // Reset while byte 10 is on the bus.
    ack_delay = 3;
    hold      = 0;
    bytes0    = byte_cnt;
    push_block(3, 1024);
    enne  = 4'd3;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (byte_cnt - bytes0 >= 10 && !dav_s) break;
      step;
    end
    check("reached_byte10", byte_cnt - bytes0, 10);
    reset = 1'b1;
    step;
    check("rst_mid_dav", dav_big, 1'b1);
    check("rst_mid_busy", busy_big, 1'b0);
    reset = 1'b0;
    q.delete();
    saved = byte_cnt;
    repeat (30) step;
    check("no_bytes_after_reset", byte_cnt, saved);
    check("idle_after_reset", busy_big, 1'b0);

    // Fresh block 0 after the abandoned one.
    run_block(0, 1024, 0, 0, 0);

    // Small-block instance, block 1 -> addresses 4..7.
    sel4 = 1'b1;
    step;
    run_block(1, 4, 0, 0, 0);
    check("done_latency", done_cyc - last_rel, 1);
    step;
    check("done_cleared", done_4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_sender.md
MEM_SENDER -- requirements
Module: mem_sender

Interface
REQ-001 Parameter CICLI, default 1024, meaning bytes per block and block stride in the address space.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 start  input  1  request to send one block; sampled only in state IDLE.
REQ-005 enne  input  4  block index; block base address = enne*CICLI, captured when start is accepted.
REQ-006 a13_a0  output  14  memory read address.
REQ-007 d7_d0  input  8  memory read data, valid one clock after a13_a0 is stable.
REQ-008 dato  output  8  byte presented to the consumer.
REQ-009 dav_  output  1  data-available strobe, active low.
REQ-010 rfd  input  1  consumer ready-for-data, active high.
REQ-011 busy  output  1  high from start acceptance until the last byte's handshake completes.
REQ-012 done  output  1  one-cycle pulse after the last byte of a block is released.

Function
REQ-013 Internal registers: STAR (state), COUNT (11 bits), A13_A0 (14 bits), DATO (8 bits), DAV_, BUSY, DONE; every output is driven directly from a register.
REQ-014 States: IDLE, RD, LATCH, WAITR, SEND, REL.
REQ-015 IDLE: dav_=1, busy=0; if start=1 then A13_A0<=enne*CICLI, COUNT<=CICLI, BUSY<=1, go to RD; else stay in IDLE.
REQ-016 RD: A13_A0 held one cycle so memory data settles; go to LATCH.
REQ-017 LATCH: DATO<=d7_d0; go to WAITR.
REQ-018 WAITR: if rfd=1 then DAV_<=0 and go to SEND; else stay in WAITR.
REQ-019 SEND: DAV_ held 0 and DATO held stable while rfd=1; when rfd=0, DAV_<=1 and go to REL.
REQ-020 REL: wait for rfd=1 (consumer ready again); then A13_A0<=A13_A0+1 and COUNT<=COUNT-1; go to RD if COUNT!=1.
REQ-021 REL with rfd=1 and COUNT==1: BUSY<=0, DONE<=1 for exactly one cycle, COUNT<=CICLI, go to IDLE.
REQ-022 dato changes only in LATCH, never while dav_=0.
REQ-023 dav_ is never asserted while rfd=0, and never re-asserted before rfd has returned to 1.
REQ-024 start asserted while busy=1 is ignored and has no effect on the transfer in progress.
REQ-025 Address arithmetic is modulo 2^14; enne=15 with CICLI=1024 covers 'h3C00-'h3FFF with no wrap.
REQ-026 Minimum time per byte, with rfd responding immediately, is 5 clocks (RD, LATCH, WAITR, SEND, REL).
REQ-027 Changes of enne while busy=1 do not affect the transfer in progress.

Reset
REQ-028 reset=1 at a rising edge: STAR<=IDLE, DAV_<=1, BUSY<=0, DONE<=0, COUNT<=CICLI, A13_A0<=0, DATO<='H00.
REQ-029 Reset during any state, including SEND with dav_=0, abandons the block; dav_ is 1 from the following edge and no further bytes are sent.
REQ-030 reset has priority over start at the same edge.

Verification
REQ-031 enne=2, start pulse, memory[i]=i[7:0], consumer answers immediately -> 1024 bytes 'H00..'HFF repeating, addresses 'h0800-'h0BFF in order, one done pulse, busy low afterwards.
REQ-032 Consumer holds rfd=0 for 20 clocks before each byte -> dav_ stays 1 in WAITR, no byte lost or duplicated, dato stable while dav_=0.
REQ-033 enne=15 -> last address 'h3FFF, done pulse, A13_A0 not wrapped into block 0 during the transfer.
REQ-034 start pulses every 3 clocks during a transfer -> single block of 1024 bytes only; a new block starts only on a start after done.
REQ-035 reset asserted while dav_=0 at byte 10 -> dav_=1 and busy=0 on the next edge; a later start with enne=0 begins at address 'h0000 with COUNT=1024.
REQ-036 CICLI=4 override, enne=1 -> 4 handshakes at addresses 4..7, done asserted exactly one cycle after the 4th release.
